non_maximum_suppression: RTL and testbench

NON_MAXIMUM_SUPPRESSION -- requirements
Module: non_maximum_suppression

---
 rtl/non_maximum_suppression_if.sv | 23 ++
 rtl/non_maximum_suppression.sv | 180 ++++++++++++++++++
 tb/tb_non_maximum_suppression.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/non_maximum_suppression_if.sv
// Stream bundle around the NMS stage: upstream FIFO read side, downstream
// FIFO write side and the end-of-frame pulse.
interface non_maximum_suppression_if;
  logic [9:0] in_dout;
  logic       in_empty;
  logic       in_rd_en;
  logic [7:0] out_din;
  logic       out_wr_en;
  logic       out_full;
  logic       frame_done;

  // Environment side: feeds the upstream FIFO word and downstream full flag.
  modport master (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en, frame_done
  );

  // NMS block side.
  modport slave (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en, frame_done
  );
endinterface

// File: rtl/non_maximum_suppression.sv
// Canny non-maximum suppression over a streamed raster image. A two-row-plus
// window shift register holds the 3x3 neighbourhood of the centre pixel; each
// pixel takes one NMS cycle (shift + compare) and one OUTPUT cycle (write).
module non_maximum_suppression #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input logic                          clock,
  input logic                          reset,
  non_maximum_suppression_if.slave     bus
);

  localparam int SR_N   = 2 * WIDTH + 3;
  localparam int CTR    = WIDTH + 1;
  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FILL_W = $clog2(WIDTH + 2);
  localparam int PIX_W  = $clog2(WIDTH * HEIGHT);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);
  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(WIDTH + 1);
  localparam logic [PIX_W-1:0]  READ_LIMIT = PIX_W'(WIDTH * HEIGHT - WIDTH - 2);

  // Window entry indices (0 = oldest / top-left, SR_N-1 = newest).
  localparam int E_TL = 0;
  localparam int E_T  = 1;
  localparam int E_TR = 2;
  localparam int E_L  = WIDTH;
  localparam int E_R  = WIDTH + 2;
  localparam int E_BL = 2 * WIDTH;
  localparam int E_B  = 2 * WIDTH + 1;
  localparam int E_BR = 2 * WIDTH + 2;

  typedef enum logic [1:0] {PROLOGUE, NMS, OUTPUT} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [7:0]          res_q, res_d;
  logic [9:0]          sr_q [SR_N];
  logic [9:0]          sr_d [SR_N];

  logic                rd_en, wr_en, do_shift, frame_end, border;
  logic [9:0]          shift_word;
  logic [7:0]          nbr_a, nbr_b;

  // Centre survives only if it is not smaller than either gradient neighbour.
  function automatic logic [7:0] nms_pick(input logic [7:0] c,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    return (c >= a && c >= b) ? c : 8'd0;
  endfunction

  // State, counters, result and window register; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PROLOGUE;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      fill_q  <= '0;
      res_q   <= '0;
      for (int i = 0; i < SR_N; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      fill_q  <= fill_d;
      res_q   <= res_d;
      for (int i = 0; i < SR_N; i++) sr_q[i] <= sr_d[i];
    end
  end

  // Handshake outputs and shift strobe; all forced low while reset is high.
  always_comb begin
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    do_shift   = 1'b0;
    frame_end  = 1'b0;
    shift_word = 10'h000;
    if (!reset) begin
      case (state_q)
        PROLOGUE: begin
          if (!bus.in_empty) begin
            rd_en      = 1'b1;
            do_shift   = 1'b1;
            shift_word = bus.in_dout;
          end
        end
        NMS: begin
          if (pix_q < READ_LIMIT) begin
            if (!bus.in_empty) begin
              rd_en      = 1'b1;
              do_shift   = 1'b1;
              shift_word = bus.in_dout;
            end
          end else begin
            // Bottom-right tail of the frame: pad with zeros, nothing to read.
            do_shift = 1'b1;
          end
        end
        OUTPUT: begin
          if (!bus.out_full) begin
            wr_en     = 1'b1;
            frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_rd_en   = rd_en;
  assign bus.out_wr_en  = wr_en;
  assign bus.out_din    = wr_en ? res_q : 8'h00;
  assign bus.frame_done = frame_end;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PROLOGUE: if (do_shift && fill_q == FILL_LAST) state_d = NMS;
      NMS:      if (do_shift) state_d = OUTPUT;
      OUTPUT:   if (wr_en) state_d = frame_end ? PROLOGUE : NMS;
      default:  state_d = PROLOGUE;
    endcase
  end

  // Neighbour pair chosen by the centre pixel's quantized gradient direction.
  always_comb begin
    nbr_a = 8'h00;
    nbr_b = 8'h00;
    case (sr_q[CTR][9:8])
      2'd0: begin nbr_a = sr_q[E_L][7:0];  nbr_b = sr_q[E_R][7:0];  end
      2'd1: begin nbr_a = sr_q[E_TR][7:0]; nbr_b = sr_q[E_BL][7:0]; end
      2'd2: begin nbr_a = sr_q[E_T][7:0];  nbr_b = sr_q[E_B][7:0];  end
      default: begin nbr_a = sr_q[E_TL][7:0]; nbr_b = sr_q[E_BR][7:0]; end
    endcase
    border = (row_q == '0) || (row_q == ROW_LAST) ||
             (col_q == '0) || (col_q == COL_LAST);
  end

  // Window shift, result capture from the pre-shift window, raster counters.
  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    res_d  = res_q;
    row_d  = row_q;
    col_d  = col_q;
    pix_d  = pix_q;
    if (do_shift) begin
      for (int i = 0; i < SR_N - 1; i++) sr_d[i] = sr_q[i+1];
      sr_d[SR_N-1] = shift_word;
    end
    if (state_q == PROLOGUE && do_shift) fill_d = fill_q + FILL_W'(1);
    if (state_q == NMS && do_shift)
      res_d = border ? 8'd0 : nms_pick(sr_q[CTR][7:0], nbr_a, nbr_b);
    if (wr_en) begin
      if (frame_end) begin
        row_d  = '0;
        col_d  = '0;
        pix_d  = '0;
        fill_d = '0;
      end else begin
        pix_d = pix_q + PIX_W'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_non_maximum_suppression.sv
// Bench for the NMS stage on an 8x6 image: a FIFO-like source queue, a
// 2-D reference model producing expected outputs into a scoreboard queue,
// and an independent monitor that pops and compares on every write.
module tb_non_maximum_suppression;
  localparam int W = 8;
  localparam int H = 6;

  typedef struct packed {
    logic [7:0] mag;
    logic       last;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  non_maximum_suppression_if bus_if ();

  non_maximum_suppression #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [9:0] src_q [$];
  exp_t       exp_q [$];
  logic [9:0] img [H][W];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int fd_count = 0;
  int rd_count = 0;
  bit empty_rand = 1'b0;
  bit full_rand  = 1'b0;
  bit full_force = 1'b0;
  bit pop_pend   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: suppression evaluated directly on the 2-D image.
  function automatic logic [7:0] ref_px(input int r, input int c);
    logic [9:0] ctr, a, b;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    ctr = img[r][c];
    case (ctr[9:8])
      2'd0: begin a = img[r][c-1];   b = img[r][c+1];   end
      2'd1: begin a = img[r-1][c+1]; b = img[r+1][c-1]; end
      2'd2: begin a = img[r-1][c];   b = img[r+1][c];   end
      default: begin a = img[r-1][c-1]; b = img[r+1][c+1]; end
    endcase
    return (ctr[7:0] >= a[7:0] && ctr[7:0] >= b[7:0]) ? ctr[7:0] : 8'd0;
  endfunction

  task automatic fill_const(input logic [7:0] mag, input logic [1:0] dir);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = {dir, mag};
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 12) * 20)};
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        src_q.push_back(img[r][c]);
        e.mag  = ref_px(r, c);
        e.last = (r == H - 1 && c == W - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clock);
      n++;
    end
    #2;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_src_empty"}, src_q.size(), 0);
  endtask

  task automatic run_frame(input string name);
    int wr0 = wr_count;
    int fd0 = fd_count;
    push_frame();
    wait_drain(name);
    check({name, "_writes"}, wr_count - wr0, W * H);
    check({name, "_frame_done"}, fd_count - fd0, 1);
  endtask

  // Upstream FIFO and downstream full flag, updated on the falling edge.
  initial begin
    bus_if.in_dout  = 10'h000;
    bus_if.in_empty = 1'b1;
    bus_if.out_full = 1'b0;
    forever begin
      @(negedge clock);
      if (pop_pend && src_q.size() != 0) begin
        void'(src_q.pop_front());
        rd_count++;
      end
      pop_pend = 1'b0;
      bus_if.in_empty = (src_q.size() == 0) || (empty_rand && $urandom_range(0, 2) == 0);
      bus_if.in_dout  = (src_q.size() != 0) ? src_q[0] : 10'($urandom);
      bus_if.out_full = full_force || (full_rand && $urandom_range(0, 3) == 0);
      #1;
      pop_pend = bus_if.in_rd_en;
    end
  end

  // Monitor: protocol rules and scoreboard comparison of every write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (bus_if.in_rd_en) check("rd_en_while_empty", int'(bus_if.in_empty), 0);
      if (bus_if.out_wr_en) check("wr_en_while_full", int'(bus_if.out_full), 0);
      if (bus_if.frame_done) check("frame_done_without_write", int'(bus_if.out_wr_en), 1);
      if (bus_if.out_wr_en) begin
        wr_count++;
        if (bus_if.frame_done) fd_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got out_din=%0d expected no write (t=%0t)",
                   bus_if.out_din, $time);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("pixel_%0d", wr_count), int'(bus_if.out_din), int'(e.mag));
          check($sformatf("last_flag_%0d", wr_count), int'(bus_if.frame_done), int'(e.last));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, fd0, rd0, n;
    logic [9:0] saved [H][W];

    // Reset with data waiting upstream: nothing may be read or written.
    reset = 1'b1;
    fill_const(8'd50, 2'd0);
    @(posedge clock); #2;
    wr0 = wr_count; fd0 = fd_count;
    push_frame();
    repeat (3) @(posedge clock);
    @(negedge clock); #2;
    check("rst_in_empty_low", int'(bus_if.in_empty), 0);
    check("rst_rd_en", int'(bus_if.in_rd_en), 0);
    check("rst_wr_en", int'(bus_if.out_wr_en), 0);
    check("rst_out_din", int'(bus_if.out_din), 0);
    check("rst_frame_done", int'(bus_if.frame_done), 0);
    check("rst_no_reads", rd_count, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    wait_drain("flat50");
    check("flat50_writes", wr_count - wr0, W * H);
    check("flat50_frame_done", fd_count - fd0, 1);

    // Single vertical-gradient peak in a flat field.
    fill_const(8'd10, 2'd0);
    img[2][3] = {2'd2, 8'd90};
    run_frame("peak90");

    // Diagonal direction, top-right neighbour larger, then equal.
    fill_const(8'd0, 2'd0);
    img[2][3] = {2'd1, 8'd40};
    img[1][4] = {2'd0, 8'd41};
    run_frame("diag_lose");
    img[1][4] = {2'd0, 8'd40};
    run_frame("diag_tie");

    // Downstream full held for five cycles while a result is waiting.
    fill_random();
    wr0 = wr_count; fd0 = fd_count;
    push_frame();
    n = 0;
    while (!bus_if.out_wr_en && n < 500) begin
      @(posedge clock); #2;
      n++;
    end
    check("stall_reached_output", int'(bus_if.out_wr_en), 1);
    full_force = 1'b1;
    n = wr_count;
    @(negedge clock); #2;
    rd0 = rd_count;
    repeat (5) @(posedge clock);
    #2;
    check("stall_no_write", wr_count - n, 0);
    check("stall_no_read", rd_count - rd0, 0);
    full_force = 1'b0;
    wait_drain("stall");
    check("stall_writes", wr_count - wr0, W * H);
    check("stall_frame_done", fd_count - fd0, 1);

    // Same random image without stalls, then with random empty/full.
    fill_random();
    saved = img;
    run_frame("rand_clean");
    img = saved;
    empty_rand = 1'b1;
    run_frame("rand_empty");
    full_rand = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fill_random();
      run_frame($sformatf("rand_both_%0d", k));
    end
    empty_rand = 1'b0;
    full_rand  = 1'b0;

    // Reset after the 20th write abandons the frame; next frame is clean.
    fill_random();
    wr0 = wr_count;
    push_frame();
    n = 0;
    while (wr_count < wr0 + 20 && n < 1000) begin
      @(posedge clock); #2;
      n++;
    end
    check("midreset_reached_20", wr_count - wr0, 20);
    reset = 1'b1;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    fill_random();
    run_frame("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
